// File: rtl/rat_uart_tx.sv
// rat_uart_tx: RAT port-bus UART transmitter (8N1, LSB first) with a small byte FIFO.
// Define RAT_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module rat_uart_tx #(
  parameter logic [7:0] DATA_ID      = 8'h80,
  parameter logic [7:0] STATUS_ID    = 8'h81,
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_DATA,
  output logic       TX
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RAT_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic          strb_d;
  logic          wr_evt;
  logic          req_data;
  logic          req_status;
  logic [7:0]    req_byte;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ovf;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] baud;
  logic [CW-1:0] baud_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          tx_n;
  logic          last_tick;
`ifdef RAT_UART_TX_PARITY_EN
  logic          par;
`endif

  // The strobe comes from the slow MCU clock; one request per rising edge,
  // registered so the bus decode is off the FIFO write path.
  assign wr_evt = IO_STRB & ~strb_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      strb_d     <= 1'b0;
      req_data   <= 1'b0;
      req_status <= 1'b0;
      req_byte   <= 8'h00;
    end else begin
      strb_d     <= IO_STRB;
      req_data   <= wr_evt && (PORT_ID == DATA_ID);
      req_status <= wr_evt && (PORT_ID == STATUS_ID);
      req_byte   <= OUT_PORT;
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = req_data & ~full;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= req_byte;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A new overflow takes priority over a clear arriving in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET)                   ovf <= 1'b0;
    else if (req_data && full)   ovf <= 1'b1;
    else if (req_status)         ovf <= 1'b0;
  end

  assign IN_DATA = (PORT_ID == STATUS_ID) ?
                   {4'b0000, ovf, (state != IDLE), empty, full} : 8'h00;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      shift <= 8'h00;
      TX    <= 1'b1;
`ifdef RAT_UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      baud  <= baud_n;
      idx   <= idx_n;
      shift <= shift_n;
      TX    <= tx_n;
`ifdef RAT_UART_TX_PARITY_EN
      if (pop) par <= ^mem[rd_ptr];
`endif
    end
  end

  assign last_tick = (baud == LAST_TICK);

  // TX is decoded from the next state so the registered line changes on the
  // same edge as the state it belongs to.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (last_tick) begin
          baud_n  = '0;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      DATA: begin
        if (last_tick) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef RAT_UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          baud_n = baud + CW'(1);
        end
      end
`ifdef RAT_UART_TX_PARITY_EN
      PARITY: begin
        if (last_tick) begin
          baud_n  = '0;
          state_n = STOP;
        end else begin
          baud_n = baud + CW'(1);
        end
      end
`endif
      STOP: begin
        if (last_tick) begin
          baud_n  = '0;
          state_n = IDLE;
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef RAT_UART_TX_PARITY_EN
      PARITY:  tx_n = par;
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_rat_uart_tx.sv
// tb_rat_uart_tx: directed bus writes feed an expected-byte queue; a serial
// monitor decodes every TX frame and checks it against the queue head.
module tb_rat_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef RAT_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = CPB * NB;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_strb;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic [7:0] in_data;
  logic       tx;

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         abort_frame = 1'b0;

  rat_uart_tx #(
    .DATA_ID(8'h80),
    .STATUS_ID(8'h81),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(clk),
    .RESET(reset),
    .PORT_ID(port_id),
    .OUT_PORT(out_port),
    .IO_STRB(io_strb),
    .IN_DATA(in_data),
    .TX(tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expected line levels in transmit order: start, data LSB first, [parity], stop.
  function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
`ifdef RAT_UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // Called on a falling edge; holds the strobe for 'hold' cycles.
  task automatic apply_stimulus(input logic [7:0] id, input logic [7:0] data,
                                input int hold, input int gap, input bit expect_tx);
    port_id  = id;
    out_port = data;
    io_strb  = 1'b1;
    if (expect_tx) exp_q.push_back(data);
    repeat (hold) @(negedge clk);
    io_strb = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int bound);
    port_id = 8'h81;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (in_data == 8'h02) break;
    end
    check_output(name, in_data, 8'h02);
  endtask

  task automatic print_summary;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  // Serial monitor: detect start bit, sample mid-bit, compare with queue head.
  initial begin : monitor
    logic [NB-1:0] bits;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        start_q.push_back(cyc);
        bits = '0;
        repeat (CPB / 2) @(negedge clk);
        bits[0] = tx;
        for (int b = 1; b < NB; b++) begin
          repeat (CPB) @(negedge clk);
          if (abort_frame) break;
          bits[b] = tx;
        end
        if (abort_frame) begin
          abort_frame = 1'b0;
        end else if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_frame: got 0x%0h, expected no frame", bits);
        end else begin
          check_output("frame", bits, frame_of(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    miscompares++;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    print_summary();
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int busy;
    int k;
    int n;
    reset    = 1'b1;
    io_strb  = 1'b0;
    port_id  = 8'h00;
    out_port = 8'h00;
    repeat (3) @(negedge clk);
    check_output("reset_tx", tx, 1'b1);
    port_id = 8'h81;
    #1 check_output("reset_status", in_data, 8'h02);
    port_id = 8'h20;
    #1 check_output("reset_other_port", in_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single byte A5, 6-cycle strobe");
    port_id  = 8'h80;
    out_port = 8'hA5;
    io_strb  = 1'b1;
    exp_q.push_back(8'hA5);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) check_output("tx_high_after_n1", tx, 1'b1);
      if (i == 3) check_output("tx_low_after_n2", tx, 1'b0);
    end
    io_strb = 1'b0;
    port_id = 8'h81;
    busy = 4;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_data[2]) busy++;
      else break;
    end
    check_output("frame_length", busy, FRAME);
    check_output("status_empty_after_a5", in_data, 8'h02);

    $display("[TB] status read with two bytes queued");
    apply_stimulus(8'h80, 8'h3C, 2, 1, 1'b1);
    apply_stimulus(8'h80, 8'hC3, 2, 1, 1'b1);
    apply_stimulus(8'h80, 8'h5A, 2, 1, 1'b1);
    port_id = 8'h81;
    @(negedge clk);
    check_output("status_busy_two_queued", in_data, 8'h04);
    wait_idle("status_drained", 400);
    port_id = 8'h20;
    #1 check_output("status_other_port", in_data, 8'h00);

    $display("[TB] overflow with six rapid writes");
    for (int v = 1; v <= 6; v++)
      apply_stimulus(8'h80, 8'(v), 1, 1, v <= 5);
    port_id = 8'h81;
    #1 check_output("status_full_busy_ovf", in_data, 8'h0D);
    apply_stimulus(8'h81, 8'h00, 1, 1, 1'b0);
    #1 check_output("status_ovf_cleared", in_data, 8'h05);
    wait_idle("overflow_drained", 600);

    $display("[TB] back-to-back 00 then FF");
    start_q.delete();
    apply_stimulus(8'h80, 8'h00, 2, 1, 1'b1);
    apply_stimulus(8'h80, 8'hFF, 2, 1, 1'b1);
    wait_idle("b2b_drained", 400);
    check_output("b2b_frame_count", start_q.size(), 2);
    if (start_q.size() >= 2)
      check_output("b2b_start_spacing", start_q[1] - start_q[0], FRAME + 1);

    $display("[TB] reset during data bit 3");
    start_q.delete();
    apply_stimulus(8'h80, 8'h11, 2, 1, 1'b1);
    apply_stimulus(8'h80, 8'h22, 2, 1, 1'b1);
    apply_stimulus(8'h80, 8'h33, 2, 1, 1'b1);
    for (int i = 0; i < 50 && start_q.size() == 0; i++) @(negedge clk);
    check_output("reset_test_frame_started", start_q.size(), 1);
    k = (start_q.size() > 0) ? start_q[0] : cyc;
    for (int i = 0; i < 100 && cyc < k + 17; i++) @(negedge clk);
    check_output("tx_data_bit3", tx, 1'b0);
    reset       = 1'b1;
    abort_frame = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check_output("tx_high_after_reset", tx, 1'b1);
    port_id = 8'h81;
    #1 check_output("status_after_reset", in_data, 8'h02);
    n = start_q.size();
    repeat (200) @(negedge clk);
    check_output("no_frames_after_reset", start_q.size(), n);
    check_output("status_still_idle", in_data, 8'h02);

`ifdef RAT_UART_TX_PARITY_EN
    $display("[TB] parity frame for 07");
    apply_stimulus(8'h80, 8'h07, 2, 1, 1'b1);
    port_id = 8'h81;
    busy = 0;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (in_data[2]) busy++;
      else break;
      @(negedge clk);
    end
    check_output("parity_frame_length", busy, 44);
    check_output("parity_drained", in_data, 8'h02);
`endif

    repeat (4) @(negedge clk);
    check_output("all_frames_seen", exp_q.size(), 0);
    print_summary();
    $finish;
  end

endmodule
